// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the systolic drain-side collector.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } collector_state_t;

    // Pointer width, never zero even for a degenerate one-column array.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/systolic_output_collector_fifo.sv
// Per-column result FIFO: registered storage, head visible the cycle after a write.
module result_column_fifo
    import systolic_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [DATA_WIDTH-1:0]      wdata_i,
    input  logic                       pop_i,
    output logic [DATA_WIDTH-1:0]      rdata_o,
    output logic                       empty_o,
    output logic [cnt_w(DEPTH)-1:0]    count_o
);

    localparam int unsigned PTR_W = idx_w(DEPTH);
    localparam int unsigned CNT_W = cnt_w(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_push;
    logic                  w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        w_pop  = pop_i && (r_count != '0);
        w_push = push_i && ((r_count != CNT_W'(DEPTH)) || w_pop);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (w_push && !clear_i) r_mem[r_wr_ptr] <= wdata_i;
    end

    assign rdata_o = r_mem[r_rd_ptr];
    assign empty_o = (r_count == '0);
    assign count_o = r_count;

endmodule

// File: rtl/systolic_output_collector.sv
// Captures skewed per-column results from the array's south edge and replays
// them as a row-major valid/ready stream.
module systolic_output_collector
    import systolic_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   start_i,
    input  logic [DATA_WIDTH-1:0]  col_data_i [0:N-1],
    input  logic [N-1:0]           col_valid_i,
    output logic [DATA_WIDTH-1:0]  result_data_o,
    output logic [idx_w(N)-1:0]    result_row_o,
    output logic [idx_w(N)-1:0]    result_col_o,
    output logic                   result_valid_o,
    input  logic                   result_ready_i,
    output logic                   result_last_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   overflow_o
);

    localparam int unsigned IDX_W = idx_w(N);
    localparam int unsigned CNT_W = cnt_w(N);

    collector_state_t      r_state;
    logic [IDX_W-1:0]      r_row;
    logic [IDX_W-1:0]      r_col;
    logic                  r_overflow;
    logic [CNT_W-1:0]      r_cap_cnt  [N];

    logic [DATA_WIDTH-1:0] w_head     [N];
    logic [CNT_W-1:0]      w_fifo_cnt [N];
    logic [N-1:0]          w_empty;
    logic [N-1:0]          w_push;
    logic [N-1:0]          w_pop;
    logic [N-1:0]          w_drop;
    logic                  w_run;
    logic                  w_clear;
    logic                  w_valid;
    logic                  w_hs;
    logic                  w_last;

    for (genvar j = 0; j < N; j++) begin : g_col
        result_column_fifo #(
            .DEPTH      (N),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rstn_i  (rstn_i),
            .clear_i (w_clear),
            .push_i  (w_push[j]),
            .wdata_i (col_data_i[j]),
            .pop_i   (w_pop[j]),
            .rdata_o (w_head[j]),
            .empty_o (w_empty[j]),
            .count_o (w_fifo_cnt[j])
        );
    end

    // Capture gating, pop steering and stream qualifiers.
    always_comb begin
        w_run   = (r_state == RUN);
        w_clear = start_i && (r_state != RUN);
        w_valid = w_run && !w_empty[r_col];
        w_hs    = w_valid && result_ready_i;
        w_last  = w_valid && (r_row == IDX_W'(N - 1)) && (r_col == IDX_W'(N - 1));
        w_push  = '0;
        w_pop   = '0;
        w_drop  = '0;
        for (int unsigned j = 0; j < N; j++) begin
            w_pop[j]  = w_hs && (r_col == IDX_W'(j));
            w_drop[j] = w_run && col_valid_i[j] && (r_cap_cnt[j] >= CNT_W'(N));
            w_push[j] = w_run && col_valid_i[j] && (r_cap_cnt[j] < CNT_W'(N))
                        && ((w_fifo_cnt[j] < CNT_W'(N)) || w_pop[j]);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned j = 0; j < N; j++) r_cap_cnt[j] <= '0;
        end else if (w_clear) begin
            for (int unsigned j = 0; j < N; j++) r_cap_cnt[j] <= '0;
        end else begin
            for (int unsigned j = 0; j < N; j++) begin
                if (w_push[j]) r_cap_cnt[j] <= r_cap_cnt[j] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start_i) begin
                        r_state    <= RUN;
                        r_row      <= '0;
                        r_col      <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                RUN: begin
                    if (|w_drop) r_overflow <= 1'b1;
                    if (w_hs) begin
                        if (w_last) begin
                            r_state <= DONE;
                            r_row   <= '0;
                            r_col   <= '0;
                        end else if (r_col == IDX_W'(N - 1)) begin
                            r_col <= '0;
                            r_row <= r_row + IDX_W'(1);
                        end else begin
                            r_col <= r_col + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign result_data_o  = w_valid ? w_head[r_col] : '0;
    assign result_row_o   = r_row;
    assign result_col_o   = r_col;
    assign result_valid_o = w_valid;
    assign result_last_o  = w_last;
    assign busy_o         = w_run;
    assign done_o         = (r_state == DONE);
    assign overflow_o     = r_overflow;

endmodule

// File: tb/tb_systolic_output_collector.sv
// Randomized and directed bench for systolic_output_collector against a
// capture-table reference model.
module tb_systolic_output_collector;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [DW-1:0] col_data [0:N-1];
    logic [N-1:0]  col_valid;
    logic          ready;
    logic [DW-1:0] r_data;
    logic [IW-1:0] r_row;
    logic [IW-1:0] r_col;
    logic          r_valid;
    logic          r_last;
    logic          busy;
    logic          done;
    logic          ovf;

    int checks   = 0;
    int failures = 0;

    systolic_output_collector #(.N(N), .DATA_WIDTH(DW)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .start_i        (start),
        .col_data_i     (col_data),
        .col_valid_i    (col_valid),
        .result_data_o  (r_data),
        .result_row_o   (r_row),
        .result_col_o   (r_col),
        .result_valid_o (r_valid),
        .result_ready_i (ready),
        .result_last_o  (r_last),
        .busy_o         (busy),
        .done_o         (done),
        .overflow_o     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: everything captured so far per column, plus the index of the
    // next element to emit in row-major order.
    bit          m_run, m_done, m_ovf;
    int          m_cnt [N];
    logic [31:0] m_cap [N][N];
    int          m_idx;
    bit          m_hs;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_run = 0; m_done = 0; m_ovf = 0; m_idx = 0;
            for (int j = 0; j < N; j++) m_cnt[j] = 0;
        end else if (m_run) begin
            m_hs = (m_cnt[m_idx % N] > m_idx / N) && ready;
            for (int j = 0; j < N; j++) begin
                if (col_valid[j]) begin
                    if (m_cnt[j] < N) begin
                        m_cap[j][m_cnt[j]] = col_data[j];
                        m_cnt[j]++;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
            if (m_hs) begin
                m_idx++;
                if (m_idx == N * N) begin
                    m_run  = 0;
                    m_done = 1;
                end
            end
        end else if (start) begin
            m_run = 1; m_done = 0; m_ovf = 0; m_idx = 0;
            for (int j = 0; j < N; j++) m_cnt[j] = 0;
        end
    end

    logic [31:0] beats [$];

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            automatic bit ev = m_run && (m_cnt[m_idx % N] > m_idx / N);
            chk("valid", r_valid, ev);
            chk("last", r_last, ev && (m_idx == N * N - 1));
            chk("busy", busy, m_run);
            chk("done", done, m_done);
            chk("overflow", ovf, m_ovf);
            if (ev) begin
                chk("data", r_data, m_cap[m_idx % N][m_idx / N]);
                chk("row", r_row, m_idx / N);
                chk("col", r_col, m_idx % N);
            end
            if (r_valid && ready) beats.push_back(r_data);
        end
    end

    task automatic idle_inputs();
        start = 0;
        col_valid = '0;
        for (int j = 0; j < N; j++) col_data[j] = $urandom;
    endtask

    // One collection: column j streams N results starting at cycle offs[j].
    task automatic run_fill(input int offs[N], input bit rand_data, input int ready_mode,
                            input int ovf_col, input int mid_start_k, input int abort_beat);
        bit finished = 0;
        beats.delete();
        start = 1;
        @(posedge clk); #1;
        start = 0;
        chk("start_busy", busy, 1);
        chk("start_clears_ovf", ovf, 0);
        for (int k = 0; k < 300; k++) begin
            for (int j = 0; j < N; j++) begin
                automatic int i = k - offs[j];
                col_valid[j] = 0;
                col_data[j]  = $urandom;
                if (i >= 0 && i < N) begin
                    col_valid[j] = 1;
                    col_data[j]  = rand_data ? $urandom : 32'(16 * i + j);
                end else if (j == ovf_col && i == N) begin
                    col_valid[j] = 1;
                    col_data[j]  = 32'hDEAD;
                end
            end
            start = (k == mid_start_k);
            case (ready_mode)
                0:       ready = 1;
                1:       ready = (k % 3 == 0);
                default: ready = ($urandom % 4) != 0;
            endcase
            @(posedge clk); #1;
            if (abort_beat >= 0 && beats.size() >= abort_beat) begin
                #1 rstn = 0;
                #1;
                chk("rst_valid", r_valid, 0);
                chk("rst_data", r_data, 0);
                chk("rst_row", r_row, 0);
                chk("rst_col", r_col, 0);
                chk("rst_last", r_last, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_ovf", ovf, 0);
                idle_inputs();
                ready = 1;
                repeat (2) @(posedge clk);
                #1 rstn = 1;
                return;
            end
            if (m_done) begin
                finished = 1;
                break;
            end
        end
        idle_inputs();
        chk("completed", finished, 1);
        @(posedge clk); #1;
        chk("done_level", done, 1);
        chk("beat_count", beats.size(), N * N);
    endtask

    task automatic chk_ramp();
        if (beats.size() == N * N)
            for (int i = 0; i < N * N; i++)
                chk("ramp_value", beats[i], 16 * (i / N) + (i % N));
    endtask

    initial begin
        int offs [N];
        rstn = 0;
        ready = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        chk("reset_valid", r_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ovf", ovf, 0);

        // Pulses while idle must be ignored.
        for (int k = 0; k < 5; k++) begin
            col_valid = 4'hF;
            for (int j = 0; j < N; j++) col_data[j] = $urandom;
            @(posedge clk); #1;
        end
        idle_inputs();
        chk("idle_busy", busy, 0);

        offs = '{0, 1, 2, 3};
        run_fill(offs, 0, 0, -1, -1, -1);
        chk_ramp();
        chk("skew_ovf", ovf, 0);

        // Pulses in DONE would overflow if they were captured.
        for (int k = 0; k < 6; k++) begin
            col_valid = 4'hF;
            @(posedge clk); #1;
        end
        idle_inputs();
        chk("done_ignores_ovf", ovf, 0);
        chk("done_holds", done, 1);

        run_fill(offs, 0, 1, -1, -1, -1);
        chk_ramp();

        offs = '{10, 1, 2, 3};
        run_fill(offs, 0, 0, -1, -1, -1);
        chk_ramp();

        offs = '{0, 1, 2, 3};
        run_fill(offs, 0, 0, 2, -1, -1);
        chk_ramp();
        chk("ovf_set", ovf, 1);
        foreach (beats[i]) chk("no_dead", beats[i] == 32'hDEAD, 0);

        run_fill(offs, 0, 0, -1, 5, -1);
        chk_ramp();
        chk("mid_start_ovf", ovf, 0);

        run_fill(offs, 0, 0, -1, -1, 7);
        run_fill(offs, 0, 0, -1, -1, -1);
        chk_ramp();

        for (int it = 0; it < 20; it++) begin
            for (int j = 0; j < N; j++) offs[j] = $urandom_range(0, 8);
            run_fill(offs, 1, 2, ($urandom % 3 == 0) ? int'($urandom_range(0, N - 1)) : -1, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
